loop_mem_seq: RTL and testbench

Memory sequencer directly downstream of the looper control FSM. On each audio sample tick it walks the eight banks in order, writing the live sample into every recording bank and reading and mixing every playing bank at a shared loop position. It tracks the loop length (`current_max`) and wraps the position at that length. When idle it runs bank-erase sweeps requested by the control FSM and acknowledges each one with `delete_clear`.

---
 rtl/loop_mem_seq.sv | 273 +++++++++++++++++++++++++++
 tb/tb_loop_mem_seq.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_mem_seq.sv
// loop_mem_seq: per-sample scan of the eight loop banks (record writes, play
// reads and mixing), loop position/length tracking, and idle-time bank erase.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting; applies reset_max/set_max, starts scans and sweeps
// SCAN_REQ  | issue the access for bank b, or skip it when it is inactive
// SCAN_WAIT | hold the request until mem_ack, accumulate read data
// SCAN_DONE | publish the saturated mix and step the loop position
// DEL_REQ   | issue a zero write to the bank being erased
// DEL_WAIT  | hold the erase write until mem_ack, then advance or finish
module loop_mem_seq #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int NBANK  = 8
) (
    input  logic                     clk100,
    input  logic                     rst_n,
    input  logic                     sample_tick,
    input  logic signed [DATA_W-1:0] rec_sample,
    input  logic [NBANK-1:0]         playing,
    input  logic [NBANK-1:0]         recording,
    input  logic                     delete,
    input  logic [2:0]               delete_bank,
    output logic                     delete_clear,
    input  logic                     set_max,
    input  logic                     reset_max,
    output logic [ADDR_W-1:0]        current_max,
    output logic [ADDR_W-1:0]        pos,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [2:0]               mem_bank,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic signed [DATA_W-1:0] mem_wdata,
    input  logic                     mem_ack,
    input  logic signed [DATA_W-1:0] mem_rdata,
    output logic signed [DATA_W-1:0] mix_out,
    output logic                     mix_valid,
    output logic                     overrun
);

    localparam int ACC_W = DATA_W + 3;
    localparam logic [2:0] LAST_BANK = 3'(NBANK - 1);
    localparam logic signed [ACC_W:0] MIX_HI =
        $signed({{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] MIX_LO =
        $signed({{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}});

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN_REQ  = 3'd1,
        SCAN_WAIT = 3'd2,
        SCAN_DONE = 3'd3,
        DEL_REQ   = 3'd4,
        DEL_WAIT  = 3'd5
    } state_t;

    state_t                    state;
    logic [2:0]                bank;
    logic [ACC_W-1:0]          acc;
    logic signed [DATA_W-1:0]  sample_q;
    logic                      tick_pend;
    logic                      set_pend;
    logic                      reset_pend;
    logic                      set_max_q;
    logic                      del_armed;
    logic                      del_ok;
    logic [2:0]                del_bank_q;
    logic [ADDR_W-1:0]         del_addr;
    logic [ADDR_W-1:0]         del_last;

    logic                      set_rise;
    logic signed [ACC_W:0]     mix_sum;
    logic signed [DATA_W-1:0]  mix_sat;
    logic [ADDR_W-1:0]         pos_step;
    logic                      in_scan;
    logic                      in_del;

    assign set_rise = set_max & ~set_max_q;
    assign in_scan  = (state == SCAN_REQ) || (state == SCAN_WAIT) || (state == SCAN_DONE);
    assign in_del   = (state == DEL_REQ) || (state == DEL_WAIT);
    // The 19-bit accumulator plus the live sample can exceed 19 bits, so sum one bit wider.
    assign mix_sum  = $signed({acc[ACC_W-1], acc})
                    + $signed({{(ACC_W+1-DATA_W){sample_q[DATA_W-1]}}, sample_q});

    // Clamp the mix to the signed sample range.
    always_comb begin
        mix_sat = mix_sum[DATA_W-1:0];
        if (mix_sum > MIX_HI) begin
            mix_sat = MIX_HI[DATA_W-1:0];
        end else if (mix_sum < MIX_LO) begin
            mix_sat = MIX_LO[DATA_W-1:0];
        end
    end

    // Normal end-of-scan position step: wrap at the loop length, or saturate with no loop.
    always_comb begin
        pos_step = pos + 1'b1;
        if ((current_max != '0) && (pos >= current_max)) begin
            pos_step = '0;
        end else if ((current_max == '0) && (pos == '1)) begin
            pos_step = pos;
        end
    end

    // Sequencer FSM with registered memory handshake, mix and loop bookkeeping.
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            state        <= IDLE;
            bank         <= '0;
            acc          <= '0;
            sample_q     <= '0;
            tick_pend    <= 1'b0;
            set_pend     <= 1'b0;
            reset_pend   <= 1'b0;
            set_max_q    <= 1'b0;
            del_armed    <= 1'b0;
            del_ok       <= 1'b0;
            del_bank_q   <= '0;
            del_addr     <= '0;
            del_last     <= '0;
            delete_clear <= 1'b0;
            current_max  <= '0;
            pos          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_bank     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mix_out      <= '0;
            mix_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            mix_valid    <= 1'b0;
            delete_clear <= 1'b0;
            set_max_q    <= set_max;
            if (set_rise) begin
                set_pend <= 1'b1;
            end
            // A new sweep may only arm once delete has been seen low after the last one.
            if (!delete && !del_armed) begin
                del_ok <= 1'b1;
            end
            if (in_scan) begin
                if (sample_tick) begin
                    overrun <= 1'b1;
                end
                if (reset_max) begin
                    reset_pend <= 1'b1;
                end
            end
            if (in_del) begin
                if (sample_tick) begin
                    tick_pend <= 1'b1;
                    sample_q  <= rec_sample;
                end
                if (reset_max) begin
                    reset_pend <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (reset_max || reset_pend) begin
                        current_max <= '0;
                        pos         <= '0;
                        reset_pend  <= 1'b0;
                        set_pend    <= 1'b0;
                    end else if (set_pend) begin
                        current_max <= pos;
                        pos         <= '0;
                        set_pend    <= set_rise;
                    end
                    if (tick_pend || sample_tick) begin
                        if (!tick_pend) begin
                            sample_q <= rec_sample;
                        end
                        tick_pend <= 1'b0;
                        bank      <= '0;
                        acc       <= '0;
                        state     <= SCAN_REQ;
                    end else if (del_armed) begin
                        state <= DEL_REQ;
                    end else if (delete && del_ok) begin
                        del_armed  <= 1'b1;
                        del_ok     <= 1'b0;
                        del_bank_q <= delete_bank;
                        del_addr   <= '0;
                        del_last   <= (current_max != '0) ? current_max : '1;
                        state      <= DEL_REQ;
                    end
                end
                SCAN_REQ: begin
                    if (recording[bank]) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_bank  <= bank;
                        mem_addr  <= pos;
                        mem_wdata <= sample_q;
                        state     <= SCAN_WAIT;
                    end else if (playing[bank]) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_bank  <= bank;
                        mem_addr  <= pos;
                        mem_wdata <= '0;
                        state     <= SCAN_WAIT;
                    end else if (bank == LAST_BANK) begin
                        state <= SCAN_DONE;
                    end else begin
                        bank <= bank + 3'd1;
                    end
                end
                SCAN_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we) begin
                            acc <= acc + {{(ACC_W-DATA_W){mem_rdata[DATA_W-1]}}, mem_rdata};
                        end
                        if (bank == LAST_BANK) begin
                            state <= SCAN_DONE;
                        end else begin
                            bank  <= bank + 3'd1;
                            state <= SCAN_REQ;
                        end
                    end
                end
                SCAN_DONE: begin
                    mix_out   <= mix_sat;
                    mix_valid <= 1'b1;
                    if (reset_pend || reset_max) begin
                        pos         <= '0;
                        current_max <= '0;
                        reset_pend  <= 1'b0;
                        set_pend    <= 1'b0;
                    end else if (set_pend || set_rise) begin
                        current_max <= pos;
                        pos         <= '0;
                        set_pend    <= 1'b0;
                    end else begin
                        pos <= pos_step;
                    end
                    state <= IDLE;
                end
                DEL_REQ: begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_bank  <= del_bank_q;
                    mem_addr  <= del_addr;
                    mem_wdata <= '0;
                    state     <= DEL_WAIT;
                end
                DEL_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (del_addr == del_last) begin
                            delete_clear <= 1'b1;
                            del_armed    <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            del_addr <= del_addr + 1'b1;
                            state    <= (tick_pend || sample_tick) ? IDLE : DEL_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loop_mem_seq.sv
// Bench for loop_mem_seq: memory responder with configurable latency, and a
// per-tick reference model of the bank scan, mix and loop position rules.
module tb_loop_mem_seq;

    localparam int AW = 23;
    localparam int DW = 16;

    typedef struct packed {
        logic          we;
        logic [2:0]    bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } tx_t;

    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic                 rst_n;
    logic                 tick_drv;
    logic                 tick_inj;
    logic                 sample_tick;
    logic signed [DW-1:0] rec_sample;
    logic [7:0]           playing;
    logic [7:0]           recording;
    logic                 delete;
    logic [2:0]           delete_bank;
    logic                 delete_clear;
    logic                 set_max;
    logic                 reset_max;
    logic [AW-1:0]        current_max;
    logic [AW-1:0]        pos;
    logic                 mem_req;
    logic                 mem_we;
    logic [2:0]           mem_bank;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] mem_wdata;
    logic                 mem_ack;
    logic signed [DW-1:0] mem_rdata;
    logic signed [DW-1:0] mix_out;
    logic                 mix_valid;
    logic                 overrun;

    logic                 ack_r = 1'b0;
    logic                 ack_inj;
    logic signed [DW-1:0] rdata_r = '0;

    assign sample_tick = tick_drv | tick_inj;
    assign mem_ack     = ack_r | ack_inj;
    assign mem_rdata   = ack_inj ? 16'sd20000 : rdata_r;

    loop_mem_seq #(.ADDR_W(AW), .DATA_W(DW), .NBANK(8)) dut (
        .clk100(clk100), .rst_n(rst_n), .sample_tick(sample_tick), .rec_sample(rec_sample),
        .playing(playing), .recording(recording), .delete(delete), .delete_bank(delete_bank),
        .delete_clear(delete_clear), .set_max(set_max), .reset_max(reset_max),
        .current_max(current_max), .pos(pos), .mem_req(mem_req), .mem_we(mem_we),
        .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mix_out(mix_out), .mix_valid(mix_valid), .overrun(overrun)
    );

    int errors = 0;
    int checks = 0;

    // responder / monitor state (written only by the responder process)
    tx_t                  txq[$];
    logic signed [DW-1:0] resp_mem[int];
    int                   wcnt = 0;
    int                   mix_cnt = 0;
    logic signed [DW-1:0] mix_last = '0;
    int                   clear_cnt = 0;
    bit                   inj_done = 1'b0;

    // test-side controls and model state
    int                   lat = 0;
    bit                   rd_const_en = 1'b0;
    logic signed [DW-1:0] rd_const = '0;
    int                   inj_addr = -1;
    tx_t                  exq[$];
    int                   tx_rd = 0;
    logic signed [DW-1:0] model_mem[int];
    logic [AW-1:0]        m_pos = '0;
    logic [AW-1:0]        m_max = '0;

    initial tick_inj = 1'b0;

    // Memory responder and output monitor, sampled on the falling edge.
    always @(negedge clk100) begin
        if (mix_valid) begin
            mix_cnt++;
            mix_last = mix_out;
        end
        if (delete_clear) clear_cnt++;
        if (ack_r) begin
            ack_r    = 1'b0;
            tick_inj = 1'b0;
        end else if (mem_req) begin
            wcnt++;
            if (wcnt > lat) begin
                wcnt  = 0;
                ack_r = 1'b1;
                if (mem_we) begin
                    resp_mem[int'({mem_bank, mem_addr})] = mem_wdata;
                end else if (rd_const_en) begin
                    rdata_r = rd_const;
                end else begin
                    rdata_r = resp_mem.exists(int'({mem_bank, mem_addr})) ?
                              resp_mem[int'({mem_bank, mem_addr})] : '0;
                end
                txq.push_back(mk_tx(mem_we, mem_bank, mem_addr, mem_we ? mem_wdata : '0));
                if (!inj_done && inj_addr >= 0 && mem_we && mem_bank == 3'd2 &&
                    int'(mem_addr) == inj_addr) begin
                    tick_inj = 1'b1;
                    inj_done = 1'b1;
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    function automatic tx_t mk_tx(input logic we, input logic [2:0] b, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d);
        tx_t t;
        t.we = we; t.bank = b; t.addr = a; t.data = d;
        return t;
    endfunction

    // Reference: one sample tick walks banks 0..7 in order at the current position.
    task automatic model_tick(input logic signed [DW-1:0] s, input bit rp, input bit sp,
                              output logic signed [DW-1:0] exp_mix);
        int sum;
        int key;
        sum = 0;
        for (int b = 0; b < 8; b++) begin
            key = int'({3'(b), m_pos});
            if (recording[b]) begin
                exq.push_back(mk_tx(1'b1, 3'(b), m_pos, s));
                model_mem[key] = s;
            end else if (playing[b]) begin
                exq.push_back(mk_tx(1'b0, 3'(b), m_pos, '0));
                if (rd_const_en) sum += int'(rd_const);
                else if (model_mem.exists(key)) sum += int'(model_mem[key]);
            end
        end
        sum += int'(s);
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        exp_mix = sum[DW-1:0];
        if (rp) begin
            m_pos = '0; m_max = '0;
        end else if (sp) begin
            m_max = m_pos; m_pos = '0;
        end else if (m_max != '0 && m_pos >= m_max) begin
            m_pos = '0;
        end else if (!(m_max == '0 && m_pos == '1)) begin
            m_pos = m_pos + 1'b1;
        end
    endtask

    task automatic send_tick(input logic signed [DW-1:0] s, output bit got,
                             output logic signed [DW-1:0] mix);
        int n0;
        n0 = mix_cnt;
        @(negedge clk100);
        rec_sample = s;
        tick_drv   = 1'b1;
        @(negedge clk100);
        tick_drv = 1'b0;
        for (int i = 0; i < 400 && mix_cnt == n0; i++) @(negedge clk100);
        got = (mix_cnt != n0);
        mix = mix_last;
    endtask

    // Counts mismatches between observed and expected transactions since the last call.
    task automatic tx_take(output int bad, output int got_n, output int exp_n);
        bad   = 0;
        got_n = txq.size() - tx_rd;
        exp_n = exq.size();
        if (got_n != exp_n) bad++;
        for (int i = 0; i < got_n && i < exp_n; i++) begin
            if (txq[tx_rd + i] !== exq[i]) bad++;
        end
        tx_rd = txq.size();
        exq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick_drv = 1'b0; rec_sample = '0; playing = '0; recording = '0;
        delete = 1'b0; delete_bank = '0; set_max = 1'b0; reset_max = 1'b0; ack_inj = 1'b0;
        repeat (3) @(negedge clk100);
        checks++;
        if ({mem_req, mem_we, mem_bank, mem_addr, mem_wdata, mix_out, mix_valid, overrun,
             delete_clear} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%0b we=%0b addr=%0d mix=%0d ovr=%0b clr=%0b, required all 0",
                     mem_req, mem_we, mem_addr, mix_out, overrun, delete_clear);
        end
        checks++;
        if (pos !== '0 || current_max !== '0) begin
            errors++;
            $display("FAIL reset_pos: pos=%0d max=%0d, required 0/0", pos, current_max);
        end
        rst_n = 1'b1;
        m_pos = '0; m_max = '0;
        repeat (2) @(negedge clk100);
    endtask

    task automatic test_no_loop();
        logic signed [DW-1:0] exp_mix, got_mix;
        bit got;
        int bad, gn, en;
        recording = 8'h01; playing = 8'h00; lat = 0;
        for (int i = 0; i < 5; i++) begin
            model_tick(16'(100 + i), 1'b0, 1'b0, exp_mix);
            send_tick(16'(100 + i), got, got_mix);
            checks++;
            if (!got || got_mix !== exp_mix) begin
                errors++;
                $display("FAIL no_loop_mix[%0d]: got %0d (valid=%0b), required %0d", i, got_mix, got, exp_mix);
            end
            tx_take(bad, gn, en);
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL no_loop_tx[%0d]: %0d bad of %0d seen, required %0d matching", i, bad, gn, en);
            end
        end
        checks++;
        if (pos !== 23'd5) begin
            errors++;
            $display("FAIL no_loop_pos: pos=%0d, required 5", pos);
        end
    endtask

    task automatic test_set_wrap();
        logic signed [DW-1:0] exp_mix, got_mix;
        bit got;
        int bad, gn, en;
        @(negedge clk100); set_max = 1'b1;
        @(negedge clk100); set_max = 1'b0;
        repeat (2) @(negedge clk100);
        m_max = m_pos; m_pos = '0;
        checks++;
        if (current_max !== 23'd5 || pos !== '0) begin
            errors++;
            $display("FAIL set_max_idle: max=%0d pos=%0d, required 5/0", current_max, pos);
        end
        recording = 8'h00; playing = 8'h01;
        for (int i = 0; i < 13; i++) begin
            model_tick(16'(i * 7 - 20), 1'b0, 1'b0, exp_mix);
            send_tick(16'(i * 7 - 20), got, got_mix);
            tx_take(bad, gn, en);
            checks++;
            if (!got || got_mix !== exp_mix || bad != 0) begin
                errors++;
                $display("FAIL wrap_tick[%0d]: mix=%0d req %0d, tx bad=%0d (%0d seen, %0d required)",
                         i, got_mix, exp_mix, bad, gn, en);
            end
        end
        checks++;
        if (current_max !== 23'd5 || pos !== m_pos) begin
            errors++;
            $display("FAIL wrap_end: max=%0d pos=%0d, required 5/%0d", current_max, pos, m_pos);
        end
    endtask

    task automatic test_saturate();
        logic signed [DW-1:0] exp_mix, got_mix;
        bit got;
        int bad, gn, en;
        recording = 8'h00; playing = 8'h07; rd_const_en = 1'b1;
        rd_const = 16'sd30000;
        model_tick(16'sd0, 1'b0, 1'b0, exp_mix);
        send_tick(16'sd0, got, got_mix);
        tx_take(bad, gn, en);
        checks++;
        if (!got || got_mix !== 16'sd32767 || bad != 0) begin
            errors++;
            $display("FAIL sat_pos: mix=%0d tx bad=%0d, required 32767 and 0", got_mix, bad);
        end
        rd_const = -16'sd30000;
        model_tick(16'sd0, 1'b0, 1'b0, exp_mix);
        send_tick(16'sd0, got, got_mix);
        tx_take(bad, gn, en);
        checks++;
        if (!got || got_mix !== -16'sd32768 || bad != 0) begin
            errors++;
            $display("FAIL sat_neg: mix=%0d tx bad=%0d, required -32768 and 0", got_mix, bad);
        end
        rd_const_en = 1'b0;
    endtask

    task automatic test_delete();
        logic signed [DW-1:0] exp_mix, got_mix;
        bit got;
        int bad, gn, en, n0, t;
        @(negedge clk100); reset_max = 1'b1;
        repeat (2) @(negedge clk100); reset_max = 1'b0;
        m_pos = '0; m_max = '0;
        @(negedge clk100);
        checks++;
        if (current_max !== '0 || pos !== '0) begin
            errors++;
            $display("FAIL reset_max_idle: max=%0d pos=%0d, required 0/0", current_max, pos);
        end
        recording = 8'h00; playing = 8'h00;
        for (int i = 0; i < 9; i++) begin
            model_tick(16'(i), 1'b0, 1'b0, exp_mix);
            send_tick(16'(i), got, got_mix);
        end
        tx_take(bad, gn, en);
        @(negedge clk100); set_max = 1'b1;
        @(negedge clk100); set_max = 1'b0;
        repeat (2) @(negedge clk100);
        m_max = m_pos; m_pos = '0;
        checks++;
        if (current_max !== 23'd9 || bad != 0) begin
            errors++;
            $display("FAIL delete_setup: max=%0d idle tx bad=%0d, required 9 and 0", current_max, bad);
        end
        recording = 8'h01; rec_sample = 16'sd777; inj_addr = 3;
        for (int a = 0; a < 4; a++) exq.push_back(mk_tx(1'b1, 3'd2, AW'(a), '0));
        model_tick(16'sd777, 1'b0, 1'b0, exp_mix);
        for (int a = 4; a < 10; a++) exq.push_back(mk_tx(1'b1, 3'd2, AW'(a), '0));
        n0 = mix_cnt;
        @(negedge clk100); delete_bank = 3'd2; delete = 1'b1;
        t = 0;
        while (clear_cnt == 0 && t < 600) begin
            @(negedge clk100);
            t++;
        end
        checks++;
        if (clear_cnt == 0) begin
            errors++;
            $display("FAIL delete_timeout: no delete_clear within %0d cycles, required one", t);
        end
        repeat (3) @(negedge clk100);
        delete = 1'b0;
        repeat (6) @(negedge clk100);
        tx_take(bad, gn, en);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL delete_tx: %0d bad of %0d seen, required %0d matching", bad, gn, en);
        end
        checks++;
        if (clear_cnt !== 1) begin
            errors++;
            $display("FAIL delete_clear_count: %0d pulses, required 1", clear_cnt);
        end
        checks++;
        if (mix_cnt !== n0 + 1 || mix_last !== exp_mix) begin
            errors++;
            $display("FAIL delete_scan_mix: %0d mixes last=%0d, required 1 with %0d",
                     mix_cnt - n0, mix_last, exp_mix);
        end
    endtask

    task automatic test_overrun_priority();
        logic signed [DW-1:0] exp_mix;
        int bad, gn, en, n0, t;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre: overrun=%0b, required 0", overrun);
        end
        lat = 3; recording = 8'h00; playing = 8'hFF;
        model_tick(16'sd1234, 1'b1, 1'b1, exp_mix);
        n0 = mix_cnt;
        @(negedge clk100); rec_sample = 16'sd1234; tick_drv = 1'b1;
        @(negedge clk100); tick_drv = 1'b0;
        repeat (4) @(negedge clk100);
        tick_drv = 1'b1; reset_max = 1'b1; set_max = 1'b1;
        @(negedge clk100);
        tick_drv = 1'b0; reset_max = 1'b0; set_max = 1'b0;
        t = 0;
        while (mix_cnt == n0 && t < 400) begin
            @(negedge clk100);
            t++;
        end
        repeat (50) @(negedge clk100);
        tx_take(bad, gn, en);
        checks++;
        if (mix_cnt !== n0 + 1 || mix_last !== exp_mix || bad != 0) begin
            errors++;
            $display("FAIL overrun_scan: %0d mixes last=%0d tx bad=%0d, required 1 with %0d and 0",
                     mix_cnt - n0, mix_last, bad, exp_mix);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: overrun=%0b, required 1", overrun);
        end
        checks++;
        if (current_max !== '0 || pos !== '0) begin
            errors++;
            $display("FAIL reset_over_set: max=%0d pos=%0d, required 0/0", current_max, pos);
        end
    endtask

    task automatic test_random();
        logic signed [DW-1:0] exp_mix, got_mix, s;
        bit got;
        int bad, gn, en;
        for (int i = 0; i < 20; i++) begin
            lat       = int'($urandom_range(0, 2));
            recording = 8'($urandom);
            playing   = 8'($urandom);
            s         = 16'($urandom);
            model_tick(s, 1'b0, 1'b0, exp_mix);
            send_tick(s, got, got_mix);
            tx_take(bad, gn, en);
            checks++;
            if (!got || got_mix !== exp_mix || bad != 0 || pos !== m_pos) begin
                errors++;
                $display("FAIL random_tick[%0d]: mix=%0d req %0d, pos=%0d req %0d, tx bad=%0d",
                         i, got_mix, exp_mix, pos, m_pos, bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [DW-1:0] exp_mix, got_mix;
        bit got;
        int bad, gn, en, n0, t;
        lat = 3; recording = 8'h00; playing = 8'h01;
        @(negedge clk100); rec_sample = 16'sd50; tick_drv = 1'b1;
        @(negedge clk100); tick_drv = 1'b0;
        t = 0;
        while (!mem_req && t < 20) begin
            @(negedge clk100);
            t++;
        end
        checks++;
        if (!mem_req) begin
            errors++;
            $display("FAIL reset_mid_req: mem_req=%0b, required 1", mem_req);
        end
        rst_n = 1'b0;
        @(negedge clk100);
        checks++;
        if ({mem_req, mem_we, mem_addr, mix_valid, mix_out, overrun, pos, current_max} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: req=%0b pos=%0d mix=%0d ovr=%0b, required all 0",
                     mem_req, pos, mix_out, overrun);
        end
        rst_n = 1'b1;
        m_pos = '0; m_max = '0;
        n0 = mix_cnt;
        ack_inj = 1'b1;
        @(negedge clk100); ack_inj = 1'b0;
        repeat (4) @(negedge clk100);
        checks++;
        if (mix_cnt !== n0 || mem_req !== 1'b0 || pos !== '0) begin
            errors++;
            $display("FAIL stale_ack: mixes=%0d req=%0b pos=%0d, required 0/0/0", mix_cnt - n0, mem_req, pos);
        end
        tx_rd = txq.size();
        lat = 0;
        model_tick(16'sd50, 1'b0, 1'b0, exp_mix);
        send_tick(16'sd50, got, got_mix);
        tx_take(bad, gn, en);
        checks++;
        if (!got || got_mix !== exp_mix || bad != 0) begin
            errors++;
            $display("FAIL post_reset_tick: mix=%0d req %0d, tx bad=%0d", got_mix, exp_mix, bad);
        end
    endtask

    initial begin
        test_reset();
        test_no_loop();
        test_set_wrap();
        test_saturate();
        test_delete();
        test_overrun_priority();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
